// File: rtl/peripheral_gpio_if.sv
// Register bus between the SOC address decoder and the GPIO peripheral.
// The master drives select/strobes/data; the slave returns read data and irq.
interface peripheral_gpio_if;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [2:0]  addr;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic        irq;

  modport master (output cs, rd, wr, addr, d_in, input d_out, irq);
  modport slave  (input cs, rd, wr, addr, d_in, output d_out, irq);
endinterface

// File: rtl/peripheral_gpio.sv
// GPIO peripheral: OUT/DIR drive, sync2 + tick-based debounce of inputs,
// rise/fall edge pending flags with write-1-to-clear and a level interrupt.
module peripheral_gpio #(
  parameter int clk_freq = 25000000,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             resetn,
  peripheral_gpio_if.slave bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe
);

  if (WIDTH < 1 || WIDTH > 16 || clk_freq < 1) begin : g_param_check
    $error("peripheral_gpio: WIDTH must be 1..16 and clk_freq positive");
  end

  localparam logic [2:0] A_OUT  = 3'd0;
  localparam logic [2:0] A_DIR  = 3'd1;
  localparam logic [2:0] A_IN   = 3'd2;
  localparam logic [2:0] A_RISE = 3'd3;
  localparam logic [2:0] A_FALL = 3'd4;
  localparam logic [2:0] A_PEND = 3'd5;
  localparam logic [2:0] A_IEN  = 3'd6;
  localparam logic [2:0] A_DEB  = 3'd7;

  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q, pend_d, irq_en_q, irq_en_d;
  logic [15:0]      deb_q, deb_d, presc_q, presc_d;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] sample_q, sample_d, stable_q, stable_d, stable_dly_q;
  logic [31:0]      d_out_q, d_out_d;
  logic             irq_q, irq_d;

  logic             wr_en, rd_en, tick;
  logic [WIDTH-1:0] wdata, agree, rise, fall, pend_clr;
  logic [31:0]      rd_val;
  logic             unused_din;

  assign unused_din = ^bus.d_in[31:16];

  always_comb begin
    wr_en = bus.cs & bus.wr;
    rd_en = bus.cs & bus.rd;
    wdata = bus.d_in[WIDTH-1:0];

    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    irq_en_d  = irq_en_q;
    deb_d     = deb_q;
    pend_clr  = '0;
    if (wr_en) begin
      case (bus.addr)
        A_OUT:   out_d     = wdata;
        A_DIR:   dir_d     = wdata;
        A_RISE:  rise_en_d = wdata;
        A_FALL:  fall_en_d = wdata;
        A_PEND:  pend_clr  = wdata;
        A_IEN:   irq_en_d  = wdata;
        A_DEB:   deb_d     = bus.d_in[15:0];
        default: ;
      endcase
    end

    // Prescaler: tick when it reaches DEB; a DEB write restarts the count
    tick    = (presc_q == deb_q);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    if (wr_en && bus.addr == A_DEB) presc_d = 16'd0;

    // A pin is accepted only when two consecutive ticks saw the same level
    agree    = ~(sync2_q ^ sample_q);
    sample_d = tick ? sync2_q : sample_q;
    stable_d = tick ? ((agree & sync2_q) | (~agree & stable_q)) : stable_q;

    rise   = stable_q & ~stable_dly_q;
    fall   = ~stable_q & stable_dly_q;
    pend_d = (pend_q & ~pend_clr) | (rise & rise_en_q) | (fall & fall_en_q);
    irq_d  = |(pend_q & irq_en_q);

    rd_val = '0;
    case (bus.addr)
      A_OUT:   rd_val[WIDTH-1:0] = out_q;
      A_DIR:   rd_val[WIDTH-1:0] = dir_q;
      A_IN:    rd_val[WIDTH-1:0] = stable_q;
      A_RISE:  rd_val[WIDTH-1:0] = rise_en_q;
      A_FALL:  rd_val[WIDTH-1:0] = fall_en_q;
      A_PEND:  rd_val[WIDTH-1:0] = pend_q;
      A_IEN:   rd_val[WIDTH-1:0] = irq_en_q;
      A_DEB:   rd_val[15:0]      = deb_q;
      default: rd_val = '0;
    endcase
    d_out_d = rd_en ? rd_val : d_out_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q        <= '0;
      dir_q        <= '0;
      rise_en_q    <= '0;
      fall_en_q    <= '0;
      pend_q       <= '0;
      irq_en_q     <= '0;
      deb_q        <= '0;
      presc_q      <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      sample_q     <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      d_out_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      out_q        <= out_d;
      dir_q        <= dir_d;
      rise_en_q    <= rise_en_d;
      fall_en_q    <= fall_en_d;
      pend_q       <= pend_d;
      irq_en_q     <= irq_en_d;
      deb_q        <= deb_d;
      presc_q      <= presc_d;
      sync1_q      <= gpio_in;
      sync2_q      <= sync1_q;
      sample_q     <= sample_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      d_out_q      <= d_out_d;
      irq_q        <= irq_d;
    end
  end

  assign gpio_out  = out_q;
  assign gpio_oe   = dir_q;
  assign bus.d_out = d_out_q;
  assign bus.irq   = irq_q;

endmodule

// File: tb/tb_peripheral_gpio.sv
// Randomised and directed bench for peripheral_gpio against a behavioural
// model that derives tick times arithmetically from the last restart point.
module tb_peripheral_gpio;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [W-1:0] gpio_in = '0;
  logic [W-1:0] gpio_out, gpio_oe;

  peripheral_gpio_if bus_if();

  peripheral_gpio #(.clk_freq(25000000), .WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus_if.slave),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model state (values as they are after the latest edge)
  logic [W-1:0] m_out, m_dir, m_rise_en, m_fall_en, m_pend, m_irq_en;
  logic [15:0]  m_deb;
  logic [W-1:0] m_pin_prev, m_pin_prev2;  // pins seen one and two edges ago
  logic [W-1:0] m_sample, m_stable, m_stable_old;
  logic [31:0]  m_dout;
  logic         m_irq;
  int           m_edge, m_origin;

  function automatic logic [31:0] m_reg(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r[W-1:0] = m_out;
      3'd1: r[W-1:0] = m_dir;
      3'd2: r[W-1:0] = m_stable;
      3'd3: r[W-1:0] = m_rise_en;
      3'd4: r[W-1:0] = m_fall_en;
      3'd5: r[W-1:0] = m_pend;
      3'd6: r[W-1:0] = m_irq_en;
      default: r[15:0] = m_deb;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge resetn) begin
    logic [W-1:0] seen, rise, fall, clr;
    logic         tick, wr_en;
    if (!resetn) begin
      m_out = '0; m_dir = '0; m_rise_en = '0; m_fall_en = '0;
      m_pend = '0; m_irq_en = '0; m_deb = '0;
      m_pin_prev = '0; m_pin_prev2 = '0;
      m_sample = '0; m_stable = '0; m_stable_old = '0;
      m_dout = '0; m_irq = 1'b0;
      m_edge = 0; m_origin = 0;
    end else begin
      m_edge++;
      seen = m_pin_prev2;
      tick = ((m_edge - m_origin) % (int'(m_deb) + 1)) == 0;
      wr_en = bus_if.cs && bus_if.wr;
      rise = m_stable & ~m_stable_old;
      fall = ~m_stable & m_stable_old;
      clr  = (wr_en && bus_if.addr == 3'd5) ? bus_if.d_in[W-1:0] : '0;
      if (bus_if.cs && bus_if.rd) m_dout = m_reg(bus_if.addr);
      m_irq  = |(m_pend & m_irq_en);
      m_pend = (m_pend & ~clr) | (rise & m_rise_en) | (fall & m_fall_en);
      m_stable_old = m_stable;
      if (tick) begin
        for (int i = 0; i < W; i++)
          if (seen[i] == m_sample[i]) m_stable[i] = seen[i];
        m_sample = seen;
      end
      if (wr_en) begin
        case (bus_if.addr)
          3'd0: m_out     = bus_if.d_in[W-1:0];
          3'd1: m_dir     = bus_if.d_in[W-1:0];
          3'd3: m_rise_en = bus_if.d_in[W-1:0];
          3'd4: m_fall_en = bus_if.d_in[W-1:0];
          3'd6: m_irq_en  = bus_if.d_in[W-1:0];
          3'd7: begin m_deb = bus_if.d_in[15:0]; m_origin = m_edge; end
          default: ;
        endcase
      end
      m_pin_prev2 = m_pin_prev;
      m_pin_prev  = gpio_in;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check("gpio_out", 32'(gpio_out), 32'(m_out));
    check("gpio_oe",  32'(gpio_oe),  32'(m_dir));
    check("d_out",    bus_if.d_out,  m_dout);
    check("irq",      32'(bus_if.irq), 32'(m_irq));
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    bus_if.cs = 1'b1; bus_if.wr = 1'b1; bus_if.rd = 1'b0;
    bus_if.addr = a; bus_if.d_in = d;
    step();
    bus_if.cs = 1'b0; bus_if.wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] v);
    bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.wr = 1'b0; bus_if.addr = a;
    step();
    bus_if.cs = 1'b0; bus_if.rd = 1'b0;
    v = bus_if.d_out;
  endtask

  initial begin
    logic [31:0] v;
    int b;
    bus_if.cs = 1'b0; bus_if.rd = 1'b0; bus_if.wr = 1'b0;
    bus_if.addr = '0; bus_if.d_in = '0;

    step(); step();
    check("rst_gpio_out", 32'(gpio_out), 32'h0);
    check("rst_d_out", bus_if.d_out, 32'h0);
    check("rst_irq", 32'(bus_if.irq), 32'h0);
    resetn = 1'b1;
    step();

    // OUT / DIR drive and readback; upper write bits ignored
    wr_reg(3'd0, 32'hFFFF_FFA5);
    check("out_drive", 32'(gpio_out), 32'hA5);
    wr_reg(3'd1, 32'h0000_000F);
    check("oe_drive", 32'(gpio_oe), 32'h0F);
    rd_reg(3'd0, v); check("rd_out", v, 32'h0000_00A5);
    rd_reg(3'd1, v); check("rd_dir", v, 32'h0000_000F);

    // Pin-to-pin latency with DEB=0 while IN is read every cycle
    wr_reg(3'd3, 32'h1);
    wr_reg(3'd6, 32'h1);
    gpio_in[0] = 1'b1;
    bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.addr = 3'd2;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 3) check("lat_in_e3", 32'(m_stable[0]), 32'h0);
      if (k == 4) begin
        check("lat_in_e4", 32'(m_stable[0]), 32'h1);
        check("lat_pend_e4", 32'(m_pend[0]), 32'h0);
        check("lat_rd_e4", bus_if.d_out, 32'h0);
      end
      if (k == 5) begin
        check("lat_pend_e5", 32'(m_pend[0]), 32'h1);
        check("lat_rd_e5", bus_if.d_out, 32'h1);
        check("lat_irq_e5", 32'(bus_if.irq), 32'h0);
      end
      if (k == 6) check("lat_irq_e6", 32'(bus_if.irq), 32'h1);
    end
    bus_if.cs = 1'b0; bus_if.rd = 1'b0;

    // PEND clear colliding with a new enabled edge keeps the bit set
    wr_reg(3'd4, 32'h1);
    wr_reg(3'd5, 32'h1);
    step(); step();
    gpio_in[0] = 1'b0;
    repeat (4) step();
    wr_reg(3'd5, 32'h1);
    rd_reg(3'd5, v); check("pend_collide", v, 32'h1);
    check("irq_collide", 32'(bus_if.irq), 32'h1);
    wr_reg(3'd5, 32'h1);
    check("irq_lag", 32'(bus_if.irq), 32'h1);
    step();
    check("irq_cleared", 32'(bus_if.irq), 32'h0);
    rd_reg(3'd5, v); check("pend_cleared", v, 32'h0);

    // Debounce with DEB=9: a 15-cycle pulse is rejected, a 40-cycle one accepted
    wr_reg(3'd3, 32'h2);
    wr_reg(3'd4, 32'h2);
    wr_reg(3'd6, 32'h2);
    wr_reg(3'd7, 32'h0000_0009);
    step();
    gpio_in[1] = 1'b1;
    repeat (15) step();
    gpio_in[1] = 1'b0;
    repeat (30) step();
    rd_reg(3'd2, v); check("short_in", v, 32'h0);
    rd_reg(3'd5, v); check("short_pend", v, 32'h0);
    gpio_in[1] = 1'b1;
    repeat (38) step();
    rd_reg(3'd2, v); check("long_in_hi", v, 32'h2);
    gpio_in[1] = 1'b0;
    repeat (40) step();
    rd_reg(3'd2, v); check("long_in_lo", v, 32'h0);
    rd_reg(3'd5, v); check("long_pend", v, 32'h2);
    rd_reg(3'd7, v); check("rd_deb", v, 32'h9);
    wr_reg(3'd5, 32'hFF);

    // Falling edge on pin 7, then reset in the middle of a debounce
    wr_reg(3'd4, 32'h80);
    gpio_in[7] = 1'b1;
    repeat (40) step();
    gpio_in[7] = 1'b0;
    repeat (40) step();
    rd_reg(3'd5, v); check("fall_pend", v, 32'h80);
    gpio_in[7] = 1'b1;
    repeat (40) step();
    gpio_in[7] = 1'b0;
    repeat (5) step();
    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check("mid_rst_out", 32'(gpio_out), 32'h0);
      check("mid_rst_oe", 32'(gpio_oe), 32'h0);
      check("mid_rst_dout", bus_if.d_out, 32'h0);
      check("mid_rst_irq", 32'(bus_if.irq), 32'h0);
    end
    resetn = 1'b1;
    repeat (25) step();
    wr_reg(3'd4, 32'h80);
    repeat (10) step();
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), v);
      check("post_rst_reg", v, (a == 4) ? 32'h80 : 32'h0);
    end
    check("post_rst_irq", 32'(bus_if.irq), 32'h0);

    // Randomised traffic, pin activity and occasional resets
    repeat (3000) begin
      bus_if.cs   = 1'($urandom_range(0, 1));
      bus_if.rd   = 1'($urandom_range(0, 1));
      bus_if.wr   = ($urandom_range(0, 3) == 0);
      bus_if.addr = 3'($urandom_range(0, 7));
      bus_if.d_in = $urandom;
      if (bus_if.addr == 3'd7) bus_if.d_in = bus_if.d_in & 32'hFFFF_0003;
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, W - 1);
        gpio_in[b] = ~gpio_in[b];
      end
      resetn = ($urandom_range(0, 799) != 0);
      step();
    end
    bus_if.cs = 1'b0; bus_if.rd = 1'b0; bus_if.wr = 1'b0;
    resetn = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
